// File: rtl/lgs_frame_loader.sv
// lgs_frame_loader: assembles a W_IN-bit word stream into FRAME_BITS-wide
// operand frames for the lgsynth91 netlists under test. The design is
// double-buffered: the next frame fills the assembly register while the
// output register presents the current frame.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   s_valid/s_ready     input word handshake; s_data is the word, s_first marks word 0
//   m_valid/m_ready     output frame handshake; m_frame is the assembled frame
//   err_resync          one-cycle pulse when s_first is accepted mid-frame
//   frame_cnt           count of delivered frames, wraps
module lgs_frame_loader #(
  parameter int unsigned W_IN       = 8,
  parameter int unsigned FRAME_BITS = 132,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [W_IN-1:0]       s_data,
  input  logic                  s_first,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FRAME_BITS-1:0] m_frame,
  output logic                  err_resync,
  output logic [CNT_W-1:0]      frame_cnt
);

  localparam int unsigned NW       = (FRAME_BITS + W_IN - 1) / W_IN;
  localparam int unsigned PAD_BITS = NW * W_IN;
  localparam int unsigned WCNT_W   = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned BASE_W   = (PAD_BITS > 1) ? $clog2(PAD_BITS) : 1;

  localparam logic [WCNT_W-1:0]     LAST_WORD = WCNT_W'(NW - 1);
  localparam logic [FRAME_BITS-1:0] WORD_MASK = FRAME_BITS'({W_IN{1'b1}});

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]            state_q,   state_d;
  logic [WCNT_W-1:0]     wcnt_q,    wcnt_d;
  logic [FRAME_BITS-1:0] asm_q,     asm_d;
  logic [FRAME_BITS-1:0] m_frame_q, m_frame_d;
  logic                  m_valid_q, m_valid_d;
  logic                  s_ready_q, s_ready_d;
  logic                  err_q,     err_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;

  logic                  accept;
  logic                  resync;
  logic [WCNT_W-1:0]     wsel;
  logic [BASE_W-1:0]     base;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FILL;
      wcnt_q    <= '0;
      asm_q     <= '0;
      m_frame_q <= '0;
      m_valid_q <= 1'b0;
      s_ready_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      asm_q     <= asm_d;
      m_frame_q <= m_frame_d;
      m_valid_q <= m_valid_d;
      s_ready_q <= s_ready_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    asm_d     = asm_q;
    m_frame_d = m_frame_q;
    m_valid_d = m_valid_q;
    s_ready_d = s_ready_q;
    err_d     = 1'b0;
    cnt_d     = cnt_q;

    accept = s_valid & s_ready_q;
    resync = s_first & (wcnt_q != '0);
    wsel   = resync ? '0 : wcnt_q;
    base   = BASE_W'(wsel) * BASE_W'(W_IN);

    // A consumed frame frees the output register unless HOLD reloads it below
    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
      cnt_d     = cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_FILL: begin
        s_ready_d = 1'b1;
        if (accept) begin
          // Shifting at frame width drops bits of the last word beyond FRAME_BITS
          asm_d = (asm_q & ~(WORD_MASK << base)) | (FRAME_BITS'(s_data) << base);
          if (resync) begin
            // Resync wins over completion: the word restarts the frame
            wcnt_d = WCNT_W'(1);
            err_d  = 1'b1;
          end else if (wcnt_q == LAST_WORD) begin
            wcnt_d    = '0;
            state_d   = ST_HOLD;
            s_ready_d = 1'b0;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        s_ready_d = 1'b0;
        if (!m_valid_q || m_ready) begin
          m_frame_d = asm_q;
          m_valid_d = 1'b1;
          state_d   = ST_FILL;
          s_ready_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_FILL;
        s_ready_d = 1'b0;
      end
    endcase
  end

  assign s_ready    = s_ready_q;
  assign m_valid    = m_valid_q;
  assign m_frame    = m_frame_q;
  assign err_resync = err_q;
  assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_lgs_frame_loader.sv
// Testbench for lgs_frame_loader: directed word streams, expected frames
// queued at stimulus time and compared by a monitor on each output consume.
module tb_lgs_frame_loader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_valid;
  logic         s_ready;
  logic [7:0]   s_data;
  logic         s_first;
  logic         m_valid;
  logic         m_ready;
  logic [131:0] m_frame;
  logic         err_resync;
  logic [15:0]  frame_cnt;

  logic [131:0] exp_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  logic [15:0]  cnt0;

  // Hand-packed frames: word k at bits [8k+7:8k], word 16 keeps its low nibble only
  localparam logic [131:0] FR_A  = 132'h0_0F0E0D0C0B0A09080706050403020100;
  localparam logic [131:0] FR_B  = 132'hF_1F1E1D1C1B1A19181716151413121110;
  localparam logic [131:0] FR_C  = 132'h5_3F3E3D3C3B3A39383736353433323130;
  localparam logic [131:0] FR_D  = 132'hA_4F4E4D4C4B4A49484746454443424140;
  localparam logic [131:0] FR_R1 = 132'h0_6F6E6D6C6B6A69686766656463626160;
  localparam logic [131:0] FR_R2 = 132'h0_9F9E9D9C9B9A99989796959493929190;
  localparam logic [131:0] FR_E  = 132'h3_BFBEBDBCBBBAB9B8B7B6B5B4B3B2B1B0;
  localparam logic [131:0] FR_G  = 132'hC_CFCECDCCCBCAC9C8C7C6C5C4C3C2C1C0;
  localparam logic [131:0] FR_H  = 132'h1_DFDEDDDCDBDAD9D8D7D6D5D4D3D2D1D0;

  lgs_frame_loader #(.W_IN(8), .FRAME_BITS(132), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_first    (s_first),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_frame    (m_frame),
    .err_resync (err_resync),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [131:0] act,
                              input logic [131:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic void fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired", name);
  endfunction

  // Monitor: every consume edge must match the oldest queued frame
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL frame: got %h expected none", m_frame);
      end else begin
        chk("frame", m_frame, exp_q.pop_front());
      end
    end
  end

  task automatic send_word(input logic [7:0] d, input logic f);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_first = f;
    while (!s_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) fail_now("s_ready_wait");
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_first = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base, input logic [7:0] last, input int gap_at);
    for (int k = 0; k < 16; k++) begin
      send_word(base + 8'(k), k == 0);
      if (k == gap_at) begin
        repeat (3) @(posedge clk);
        #1;
      end
    end
    send_word(last, 1'b0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) fail_now("drain");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_first = 1'b0;
    m_ready = 1'b0;
    #12;
    chk("rst_m_valid", 132'(m_valid), 132'd0);
    chk("rst_s_ready", 132'(s_ready), 132'd0);
    chk("rst_m_frame", m_frame, 132'd0);
    chk("rst_cnt", 132'(frame_cnt), 132'd0);
    chk("rst_err", 132'(err_resync), 132'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("s_ready_before_edge", 132'(s_ready), 132'd0);
    @(posedge clk);
    #1;
    chk("s_ready_after_edge", 132'(s_ready), 132'd1);

    // Basic frame and latency
    m_ready = 1'b1;
    exp_q.push_back(FR_A);
    send_frame(8'h00, 8'h10, -1);
    chk("lat_m_valid_t1", 132'(m_valid), 132'd0);
    @(posedge clk);
    #1;
    chk("lat_m_valid_t2", 132'(m_valid), 132'd1);
    @(posedge clk);
    #1;
    chk("cnt_after_A", 132'(frame_cnt), 132'd1);

    // Last-word upper bits are discarded
    exp_q.push_back(FR_B);
    exp_q.push_back(FR_B);
    send_frame(8'h10, 8'hFF, -1);
    send_frame(8'h10, 8'h0F, -1);
    wait_drain();

    // Backpressure: hold first frame, then consume with simultaneous reload
    m_ready = 1'b0;
    cnt0 = frame_cnt;
    exp_q.push_back(FR_C);
    exp_q.push_back(FR_D);
    send_frame(8'h30, 8'h05, -1);
    send_frame(8'h40, 8'h0A, -1);
    chk("bp_s_ready", 132'(s_ready), 132'd0);
    chk("bp_m_valid", 132'(m_valid), 132'd1);
    chk("bp_hold_C", m_frame, FR_C);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_stable_C", m_frame, FR_C);
    chk("bp_s_ready_still", 132'(s_ready), 132'd0);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    chk("bp_m_valid_kept", 132'(m_valid), 132'd1);
    chk("bp_reload_D", m_frame, FR_D);
    chk("bp_cnt", 132'(frame_cnt), 132'(16'(cnt0 + 16'd1)));
    m_ready = 1'b1;
    wait_drain();

    // Resync at word 5
    exp_q.push_back(FR_R1);
    for (int k = 0; k < 5; k++) send_word(8'h50 + 8'(k), k == 0);
    send_word(8'h60, 1'b1);
    chk("r1_err_pulse", 132'(err_resync), 132'd1);
    send_word(8'h61, 1'b0);
    chk("r1_err_clear", 132'(err_resync), 132'd0);
    for (int k = 2; k < 17; k++) send_word(8'h60 + 8'(k), 1'b0);
    wait_drain();

    // Resync on the would-be last word: no frame, restart
    exp_q.push_back(FR_R2);
    for (int k = 0; k < 16; k++) send_word(8'h80 + 8'(k), k == 0);
    send_word(8'h90, 1'b1);
    chk("r2_err_pulse", 132'(err_resync), 132'd1);
    chk("r2_stay_fill", 132'(s_ready), 132'd1);
    send_word(8'h91, 1'b0);
    chk("r2_err_clear", 132'(err_resync), 132'd0);
    chk("r2_no_frame", 132'(m_valid), 132'd0);
    for (int k = 2; k < 17; k++) send_word(8'h90 + 8'(k), 1'b0);
    wait_drain();

    // Asynchronous reset mid-frame with a frame held at the output
    m_ready = 1'b0;
    send_frame(8'hB0, 8'hB3, -1);
    for (int k = 0; k < 9; k++) send_word(8'hE0 + 8'(k), k == 0);
    chk("pre_rst_m_valid", 132'(m_valid), 132'd1);
    chk("pre_rst_m_frame", m_frame, FR_E);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_m_valid", 132'(m_valid), 132'd0);
    chk("arst_m_frame", m_frame, 132'd0);
    chk("arst_cnt", 132'(frame_cnt), 132'd0);
    chk("arst_s_ready", 132'(s_ready), 132'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_s_ready_rise", 132'(s_ready), 132'd1);

    // Fresh frame after reset, with idle cycles mid-frame
    m_ready = 1'b1;
    exp_q.push_back(FR_G);
    send_frame(8'hC0, 8'h0C, 8);
    wait_drain();
    chk("cnt_after_G", 132'(frame_cnt), 132'd1);

    // Counter wrap
    @(posedge clk);
    #1;
    force dut.cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.cnt_q;
    #1;
    chk("cnt_preload", 132'(frame_cnt), 132'h0FFFF);
    exp_q.push_back(FR_H);
    send_frame(8'hD0, 8'h01, -1);
    wait_drain();
    chk("cnt_wrap", 132'(frame_cnt), 132'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
